// File: rtl/ysyx_22041211_exu_muldiv.sv
// rtl/ysyx_22041211_exu_muldiv.sv - iterative RV32M mul/div unit; optional divide-result cache via YSYX_22041211_MD_DIV_CACHE_EN
module ysyx_22041211_exu_muldiv #(
   parameter int DATA_LEN = 32,
   parameter int TAG_LEN  = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2:0]          md_op_i,
   input  logic [DATA_LEN-1:0] src1_i,
   input  logic [DATA_LEN-1:0] src2_i,
   input  logic [TAG_LEN-1:0]  tag_i,
   input  logic                flush_i,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_LEN-1:0] result_o,
   output logic [TAG_LEN-1:0]  tag_o,
   output logic                busy_o
);
   localparam int CNT_W = $clog2(DATA_LEN + 1);
   localparam logic [DATA_LEN-1:0] MIN_VAL = {1'b1, {(DATA_LEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          op_q, op_d;
   logic [TAG_LEN-1:0]  tag_q, tag_d;
   logic [DATA_LEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, result_q, result_d;
   logic                nega_q, nega_d, negb_q, negb_d;

   // Operand decode at dispatch: signedness, magnitudes and the single-cycle special cases
   logic                is_div, sgn1, sgn2, neg1, neg2, div_zero, div_ovf, special, accept;
   logic [DATA_LEN-1:0] mag1, mag2, special_res;
   assign is_div   = md_op_i[2];
   assign sgn1     = (md_op_i == 3'b001) || (md_op_i == 3'b010) || (md_op_i == 3'b100) || (md_op_i == 3'b110);
   assign sgn2     = (md_op_i == 3'b001) || (md_op_i == 3'b100) || (md_op_i == 3'b110);
   assign neg1     = sgn1 && src1_i[DATA_LEN-1];
   assign neg2     = sgn2 && src2_i[DATA_LEN-1];
   assign mag1     = neg1 ? -src1_i : src1_i;
   assign mag2     = neg2 ? -src2_i : src2_i;
   assign div_zero = is_div && (src2_i == '0);
   assign div_ovf  = is_div && !md_op_i[0] && (src1_i == MIN_VAL) && (src2_i == '1);
   assign special  = div_zero || div_ovf;
   assign special_res = div_zero ? (md_op_i[1] ? src1_i : '1) : (md_op_i[1] ? '0 : src1_i);
   assign accept   = in_valid && in_ready && !flush_i;

   // One iteration step: shift-add multiply (hi:lo shifts right) or restoring divide (hi:lo shifts left)
   logic [DATA_LEN:0]     mul_sum, div_sh, div_diff;
   logic [DATA_LEN-1:0]   mul_hi, mul_lo, div_hi, div_lo, quot_s, rem_s, mul_res, div_res;
   logic [2*DATA_LEN-1:0] prod, prod_s;
   logic                  div_ok, calc_last;
   assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(DATA_LEN+1){1'b0}});
   assign mul_hi   = mul_sum[DATA_LEN:1];
   assign mul_lo   = {mul_sum[0], lo_q[DATA_LEN-1:1]};
   assign div_sh   = {hi_q, lo_q[DATA_LEN-1]};
   assign div_diff = div_sh - {1'b0, b_q};
   assign div_ok   = !div_diff[DATA_LEN];
   assign div_hi   = div_ok ? div_diff[DATA_LEN-1:0] : div_sh[DATA_LEN-1:0];
   assign div_lo   = {lo_q[DATA_LEN-2:0], div_ok};
   assign prod     = {mul_hi, mul_lo};
   assign prod_s   = (nega_q ^ negb_q) ? -prod : prod;
   assign mul_res  = (op_q[1:0] == 2'b00) ? prod_s[DATA_LEN-1:0] : prod_s[2*DATA_LEN-1:DATA_LEN];
   assign quot_s   = (nega_q ^ negb_q) ? -div_lo : div_lo;
   assign rem_s    = nega_q ? -div_hi : div_hi;
   assign div_res  = op_q[1] ? rem_s : quot_s;
   assign calc_last = (state_q == S_CALC) && (cnt_q == CNT_W'(1)) && !flush_i;

   logic                cache_hit;
   logic [DATA_LEN-1:0] cache_res;
`ifdef YSYX_22041211_MD_DIV_CACHE_EN
   logic                c_valid_q, c_valid_d, c_sgn_q, c_sgn_d;
   logic [DATA_LEN-1:0] c_a_q, c_a_d, c_b_q, c_b_d, c_quot_q, c_quot_d, c_rem_q, c_rem_d;
   logic [DATA_LEN-1:0] a_raw_q, a_raw_d, b_raw_q, b_raw_d;
   assign cache_hit = is_div && c_valid_q && (src1_i == c_a_q) && (src2_i == c_b_q) && (c_sgn_q == !md_op_i[0]);
   assign cache_res = md_op_i[1] ? c_rem_q : c_quot_q;

   // Remember raw operands of the op in flight and capture the last normally completed division
   always_comb begin
      a_raw_d   = a_raw_q;
      b_raw_d   = b_raw_q;
      c_valid_d = c_valid_q;
      c_sgn_d   = c_sgn_q;
      c_a_d     = c_a_q;
      c_b_d     = c_b_q;
      c_quot_d  = c_quot_q;
      c_rem_d   = c_rem_q;
      if (accept) begin
         a_raw_d = src1_i;
         b_raw_d = src2_i;
      end
      if (calc_last && op_q[2]) begin
         c_valid_d = 1'b1;
         c_sgn_d   = !op_q[0];
         c_a_d     = a_raw_q;
         c_b_d     = b_raw_q;
         c_quot_d  = quot_s;
         c_rem_d   = rem_s;
      end
   end

   // Cache registers; only reset clears them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_raw_q   <= '0;
         b_raw_q   <= '0;
         c_valid_q <= 1'b0;
         c_sgn_q   <= 1'b0;
         c_a_q     <= '0;
         c_b_q     <= '0;
         c_quot_q  <= '0;
         c_rem_q   <= '0;
      end else begin
         a_raw_q   <= a_raw_d;
         b_raw_q   <= b_raw_d;
         c_valid_q <= c_valid_d;
         c_sgn_q   <= c_sgn_d;
         c_a_q     <= c_a_d;
         c_b_q     <= c_b_d;
         c_quot_q  <= c_quot_d;
         c_rem_q   <= c_rem_d;
      end
   end
`else
   assign cache_hit = 1'b0;
   assign cache_res = '0;
`endif

   // Next-state logic: dispatch, iterate, hold the result until WB takes it; flush wins
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      tag_d    = tag_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;
      result_d = result_q;
      nega_d   = nega_q;
      negb_d   = negb_q;
      if (flush_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  op_d   = md_op_i;
                  tag_d  = tag_i;
                  nega_d = neg1;
                  negb_d = neg2;
                  if (special) begin
                     result_d = special_res;
                     state_d  = S_DONE;
                  end else if (cache_hit) begin
                     result_d = cache_res;
                     state_d  = S_DONE;
                  end else begin
                     cnt_d   = CNT_W'(DATA_LEN);
                     hi_d    = '0;
                     lo_d    = is_div ? mag1 : mag2;
                     b_d     = is_div ? mag2 : mag1;
                     state_d = S_CALC;
                  end
               end
            end
            S_CALC: begin
               hi_d  = op_q[2] ? div_hi : mul_hi;
               lo_d  = op_q[2] ? div_lo : mul_lo;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  result_d = op_q[2] ? div_res : mul_res;
                  state_d  = S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         tag_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         result_q <= '0;
         nega_q   <= 1'b0;
         negb_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         tag_q    <= tag_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
         result_q <= result_d;
         nega_q   <= nega_d;
         negb_q   <= negb_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy_o    = (state_q != S_IDLE);
   assign result_o  = result_q;
   assign tag_o     = tag_q;
endmodule

// File: tb/tb_ysyx_22041211_exu_muldiv.sv
// tb/tb_ysyx_22041211_exu_muldiv.sv - self-checking bench for ysyx_22041211_exu_muldiv
module tb_ysyx_22041211_exu_muldiv;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  md_op_i = 3'd0;
   logic [31:0] src1_i = '0;
   logic [31:0] src2_i = '0;
   logic [4:0]  tag_i = '0;
   logic        flush_i = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result_o;
   logic [4:0]  tag_o;
   logic        busy_o;

   ysyx_22041211_exu_muldiv #(.DATA_LEN(32), .TAG_LEN(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .md_op_i(md_op_i), .src1_i(src1_i), .src2_i(src2_i), .tag_i(tag_i),
      .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready),
      .result_o(result_o), .tag_o(tag_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

`ifdef YSYX_22041211_MD_DIV_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   typedef struct {
      logic [31:0] res;
      logic [4:0]  tag;
      int          lat;
   } exp_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  tag;
      logic [31:0] exp;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[12];
   int   pass_cnt = 0;
   int   total_cnt = 0;

   bit          tc_valid = 1'b0;
   bit          tc_sgn = 1'b0;
   logic [31:0] tc_a = '0;
   logic [31:0] tc_b = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ub, p;
      logic [63:0] up;
      logic ovf;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ub  = {32'd0, b};
      up  = {32'd0, a} * {32'd0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         3'd0: return up[31:0];
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: return up[63:32];
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
      if (CACHE && op[2] && tc_valid && tc_a == a && tc_b == b && tc_sgn == !op[0]) return 1;
      return 32;
   endfunction

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp_res, input string name, input int hold);
      exp_t e;
      int   cyc;
      int   n;
      bit   stable;
      logic [31:0] r0;
      @(negedge clk);
      in_valid = 1'b1; md_op_i = op; src1_i = a; src2_i = b; tag_i = tag;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      #1;
      in_valid = 1'b0; src1_i = ~a; src2_i = a ^ b; tag_i = ~tag;
      sb_q.push_back('{exp_res, tag, exp_lat(op, a, b)});
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!out_valid && cyc < 100);
      e = sb_q.pop_front();
      if (!out_valid) begin
         check({name, " timeout"}, 64'(out_valid), 64'd1);
         return;
      end
      check({name, " latency"}, 64'(cyc), 64'(e.lat));
      check({name, " result"}, 64'(result_o), 64'(e.res));
      check({name, " tag"}, 64'(tag_o), 64'(e.tag));
      if (hold > 0) begin
         stable = 1'b1;
         r0 = result_o;
         repeat (hold) begin
            @(posedge clk);
            #1;
            stable &= (result_o == r0) && (tag_o == e.tag) && out_valid && !in_ready;
         end
         check({name, " hold stable"}, 64'(stable), 64'd1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({name, " back to idle"}, {62'd0, in_ready, out_valid}, 64'b10);
      if (op[2] && e.lat == 32) begin
         tc_valid = 1'b1; tc_a = a; tc_b = b; tc_sgn = !op[0];
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Stimulus: reset, vector table, random ops, backpressure, flush and async reset sequences
   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      bit          seen;
      vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
      vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};
      vecs[2]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd2,  32'h4000_0000};
      vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF};
      vecs[4]  = '{3'd4, 32'd5,          32'd0,         5'd4,  32'hFFFF_FFFF};
      vecs[5]  = '{3'd6, 32'd5,          32'd0,         5'd6,  32'd5};
      vecs[6]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd7,  32'h8000_0000};
      vecs[7]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8,  32'd0};
      vecs[8]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD};
      vecs[9]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF};
      vecs[10] = '{3'd5, 32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF};
      vecs[11] = '{3'd7, 32'd9,          32'd0,         5'd12, 32'd9};

      #1;
      check("reset state", {55'd0, out_valid, busy_o, result_o == 0, tag_o == 0}, {55'd0, 4'b0011});
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("in_ready after reset", 64'(in_ready), 64'd1);

      for (int i = 0; i < 12; i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp, $sformatf("vec%0d", i), 0);

      for (int i = 0; i < 10; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = (i == 3) ? 32'd0 : $urandom;
         run_op(rop, ra, rb, 5'(i + 16), ref_model(rop, ra, rb), $sformatf("rnd%0d", i), 0);
      end

      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, "backpressure", 10);

      // flush during the fifth CALC cycle, with a competing in_valid that must be ignored
      @(negedge clk);
      in_valid = 1'b1; md_op_i = 3'd5; src1_i = 32'd1000; src2_i = 32'd3; tag_i = 5'd20;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      flush_i = 1'b1; in_valid = 1'b1; md_op_i = 3'd0; src1_i = 32'd3; src2_i = 32'd4;
      @(posedge clk);
      #1;
      flush_i = 1'b0; in_valid = 1'b0;
      check("flush to idle", {61'd0, busy_o, in_ready, out_valid}, 64'b010);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         seen |= out_valid;
      end
      check("flush no out_valid", 64'(seen), 64'd0);
      run_op(3'd5, 32'd1000, 32'd3, 5'd21, 32'd333, "after flush", 0);

      // asynchronous reset between edges in CALC
      @(negedge clk);
      in_valid = 1'b1; md_op_i = 3'd3; src1_i = 32'd12345; src2_i = 32'd678;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async reset", {62'd0, out_valid, busy_o}, 64'd0);
      tc_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("after async reset", {61'd0, in_ready, result_o == 0, tag_o == 0}, 64'b111);

      run_op(3'd5, 32'd100, 32'd7, 5'd13, 32'd14, "divu 100/7", 0);
      run_op(3'd7, 32'd100, 32'd7, 5'd14, 32'd2, "remu 100/7", 0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd15, 32'hFFFF_FFFD, "div -7/2", 0);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd16, 32'hFFFF_FFFF, "rem -7/2", 0);
      run_op(3'd7, 32'hFFFF_FFF9, 32'd2, 5'd17, 32'd1, "remu -7/2", 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
